zigzag_rle_serializer: RTL and testbench

Consumer of the 512-bit zigzag-ordered block produced by the 64x8 zigzag buffer. Accepts one block per valid/ready handshake into a ping-pong buffer. Walks the block in zigzag order and emits JPEG-style run/value symbols (DC, AC, ZRL, EOB) one per handshake toward the Huffman/entropy stage.

---
 rtl/zigzag_rle_serializer.sv | 204 ++++++++++++++++++++
 tb/tb_zigzag_rle_serializer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/zigzag_rle_serializer.sv
// Zigzag run-length serializer.
// Accepts zigzag-ordered coefficient blocks into a two-bank ping-pong store.
// Each stored block is walked in zigzag order and emitted as DC/AC/ZRL/EOB
// symbols, one symbol per output handshake.
//
// state   | meaning
// IDLE    | no stored block is waiting to be read
// DC      | presenting the DC coefficient of the block in bank rd_ptr
// AC_SCAN | walking positions 1..last_nz, skipping zeros and emitting AC/ZRL
// EOB     | presenting the end-of-block symbol
module zigzag_rle_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64,
  localparam int IDX_W     = $clog2(DEPTH),
  localparam int BLK_W     = DATA_WIDTH * DEPTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BLK_W-1:0]      zigzag_pix_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            sym_type,
  output logic [3:0]            sym_run,
  output logic [DATA_WIDTH-1:0] sym_value,
  output logic [IDX_W-1:0]      sym_index,
  output logic                  sym_last
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DC      = 2'd1,
    S_AC_SCAN = 2'd2,
    S_EOB     = 2'd3
  } state_e;

  localparam logic [1:0] T_DC  = 2'b00;
  localparam logic [1:0] T_AC  = 2'b01;
  localparam logic [1:0] T_ZRL = 2'b10;
  localparam logic [1:0] T_EOB = 2'b11;
  localparam logic [IDX_W-1:0] POS_MAX = IDX_W'(DEPTH - 1);

  logic [BLK_W-1:0]      bank_q [2];
  logic [IDX_W-1:0]      last_nz_q [2];
  logic [1:0]            full_q;
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      pos_q, pos_d;
  logic [3:0]            run_q, run_d;

  logic [IDX_W-1:0]      last_nz_in;
  logic [IDX_W-1:0]      last_nz_cur;
  logic [DATA_WIDTH-1:0] coef0;
  logic [DATA_WIDTH-1:0] coef_cur;
  logic                  accept;
  logic                  release_blk;

  // in_ready depends only on registered bank occupancy
  assign in_ready = ~full_q[wr_ptr_q];
  assign accept   = in_valid & in_ready;

  // Highest nonzero AC index of the incoming block; 0 when all AC are zero
  always_comb begin
    last_nz_in = '0;
    for (int k = 1; k < DEPTH; k++) begin
      if (zigzag_pix_in[BLK_W-1-k*DATA_WIDTH -: DATA_WIDTH] != '0) begin
        last_nz_in = IDX_W'(k);
      end
    end
  end

  // Coefficient selection from the bank being read
  always_comb begin
    last_nz_cur = last_nz_q[rd_ptr_q];
    coef0       = bank_q[rd_ptr_q][BLK_W-1 -: DATA_WIDTH];
    coef_cur    = bank_q[rd_ptr_q][BLK_W-1-int'(pos_q)*DATA_WIDTH -: DATA_WIDTH];
  end

  // Block data storage; contents are qualified by full_q so no reset is needed
  always_ff @(posedge clock) begin
    if (accept) begin
      bank_q[wr_ptr_q] <= zigzag_pix_in;
    end
  end

  // Bank occupancy and ping-pong pointers; accept and release hit different banks
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      full_q       <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      last_nz_q[0] <= '0;
      last_nz_q[1] <= '0;
    end else begin
      if (accept) begin
        full_q[wr_ptr_q]    <= 1'b1;
        last_nz_q[wr_ptr_q] <= last_nz_in;
        wr_ptr_q            <= ~wr_ptr_q;
      end
      if (release_blk) begin
        full_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q         <= ~rd_ptr_q;
      end
    end
  end

  // FSM state, scan position and zero-run registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pos_q   <= '0;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      run_q   <= run_d;
    end
  end

  // Next-state and symbol outputs; everything frozen while a symbol is held
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    run_d       = run_q;
    out_valid   = 1'b0;
    sym_type    = T_DC;
    sym_run     = '0;
    sym_value   = '0;
    sym_index   = '0;
    sym_last    = 1'b0;
    release_blk = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (full_q[rd_ptr_q]) state_d = S_DC;
      end
      S_DC: begin
        out_valid = 1'b1;
        sym_type  = T_DC;
        sym_value = coef0;
        if (out_ready) begin
          if (last_nz_cur == '0) begin
            state_d = S_EOB;
          end else begin
            state_d = S_AC_SCAN;
            pos_d   = IDX_W'(1);
            run_d   = '0;
          end
        end
      end
      S_AC_SCAN: begin
        if (coef_cur == '0) begin
          if (run_q != 4'd15) begin
            run_d = run_q + 4'd1;
            pos_d = pos_q + 1'b1;
          end else begin
            // sixteenth consecutive zero: a nonzero is guaranteed further on
            out_valid = 1'b1;
            sym_type  = T_ZRL;
            sym_run   = 4'd15;
            if (out_ready) begin
              run_d = '0;
              pos_d = pos_q + 1'b1;
            end
          end
        end else begin
          out_valid = 1'b1;
          sym_type  = T_AC;
          sym_run   = run_q;
          sym_value = coef_cur;
          sym_index = pos_q;
          sym_last  = (pos_q == POS_MAX);
          if (out_ready) begin
            if (pos_q == POS_MAX) begin
              release_blk = 1'b1;
            end else if (pos_q == last_nz_cur) begin
              state_d = S_EOB;
            end else begin
              run_d = '0;
              pos_d = pos_q + 1'b1;
            end
          end
        end
      end
      S_EOB: begin
        out_valid = 1'b1;
        sym_type  = T_EOB;
        sym_last  = 1'b1;
        if (out_ready) release_blk = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (release_blk) begin
      state_d = full_q[~rd_ptr_q] ? S_DC : S_IDLE;
      pos_d   = '0;
      run_d   = '0;
    end
  end

endmodule

// File: tb/tb_zigzag_rle_serializer.sv
// Randomized bench for zigzag_rle_serializer with a queue-based symbol model.
module tb_zigzag_rle_serializer;

  logic         clock;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] zigzag_pix_in;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   sym_type;
  logic [3:0]   sym_run;
  logic [7:0]   sym_value;
  logic [5:0]   sym_index;
  logic         sym_last;

  zigzag_rle_serializer dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .zigzag_pix_in (zigzag_pix_in),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .sym_type      (sym_type),
    .sym_run       (sym_run),
    .sym_value     (sym_value),
    .sym_index     (sym_index),
    .sym_last      (sym_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  logic [20:0] exp_q[$];
  int          rdy_mode = 1;   // 0: never ready, 1: always ready, 2: random
  int          blocks_done = 0;
  logic        hold_v = 1'b0;
  logic [20:0] held;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [20:0] pack(input logic [1:0] t, input logic [3:0] r,
                                       input logic [7:0] v, input logic [5:0] i,
                                       input logic l);
    return {t, r, v, i, l};
  endfunction

  // JPEG run/value rules: every 16 zeros before a nonzero become one ZRL,
  // EOB closes the block unless the final AC sits at index 63
  task automatic model_push(input logic [511:0] blk);
    logic [7:0] c [64];
    int last = 0;
    int run  = 0;
    for (int k = 0; k < 64; k++) c[k] = blk[511-8*k -: 8];
    for (int k = 1; k < 64; k++) if (c[k] != 0) last = k;
    exp_q.push_back(pack(2'b00, 4'd0, c[0], 6'd0, 1'b0));
    for (int k = 1; k <= last; k++) begin
      if (c[k] == 0) begin
        run++;
      end else begin
        while (run >= 16) begin
          exp_q.push_back(pack(2'b10, 4'd15, 8'd0, 6'd0, 1'b0));
          run -= 16;
        end
        exp_q.push_back(pack(2'b01, 4'(run), c[k], 6'(k), k == 63));
        run = 0;
      end
    end
    if (last < 63) exp_q.push_back(pack(2'b11, 4'd0, 8'd0, 6'd0, 1'b1));
  endtask

  function automatic logic [511:0] set_coef(input logic [511:0] blk, input int k,
                                            input logic [7:0] v);
    logic [511:0] b = blk;
    b[511-8*k -: 8] = v;
    return b;
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b = '0;
    int dens = $urandom_range(0, 60);
    for (int k = 0; k < 64; k++)
      if ($urandom_range(0, 99) < dens) b = set_coef(b, k, 8'($urandom_range(1, 255)));
    return b;
  endfunction

  // Output monitor: drives out_ready, checks accepted symbols and stall stability
  always @(negedge clock) begin
    logic [20:0] cur;
    if (!reset_n) begin
      hold_v = 1'b0;
    end else begin
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      cur = {sym_type, sym_run, sym_value, sym_index, sym_last};
      if (hold_v) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_sym", 32'(cur), 32'(held));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("sym_extra", 32'(cur), 32'h1fffff);
        else chk("sym", 32'(cur), 32'(exp_q.pop_front()));
        if (sym_last) blocks_done++;
      end
      hold_v = out_valid && !out_ready;
      held   = cur;
    end
  end

  task automatic send_block(input logic [511:0] blk);
    int t = 0;
    @(negedge clock);
    while (!in_ready && t < 2000) begin
      @(negedge clock);
      t++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'd0, 32'd1);
    end else begin
      in_valid      = 1'b1;
      zigzag_pix_in = blk;
      model_push(blk);
      @(negedge clock);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string tag);
    int t = 0;
    while (exp_q.size() != 0 && t < 4000) begin
      @(negedge clock);
      t++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clock);
    #1;
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [511:0] b;
    int base;
    int t;
    reset_n       = 1'b0;
    in_valid      = 1'b0;
    zigzag_pix_in = '0;
    out_ready     = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_sym", 32'({sym_type, sym_run, sym_value, sym_index, sym_last}), 32'd0);
    reset_n = 1'b1;

    // directed blocks
    rdy_mode = 1;
    send_block('0);
    wait_drain("drain_zero");
    b = '0; b = set_coef(b, 0, 8'h05); b = set_coef(b, 1, 8'hFD); b = set_coef(b, 5, 8'h07);
    send_block(b);
    wait_drain("drain_basic");
    b = '0; b = set_coef(b, 20, 8'h01);
    send_block(b);
    wait_drain("drain_idx20");
    b = '0; b = set_coef(b, 63, 8'h02);
    send_block(b);
    wait_drain("drain_idx63");

    // back-to-back with both banks full
    rdy_mode = 0;
    base = blocks_done;
    send_block(rand_block());
    send_block(rand_block());
    @(negedge clock);
    chk("in_ready_full", 32'(in_ready), 32'd0);
    rdy_mode = 2;
    t = 0;
    while (t < 2000) begin
      @(negedge clock);
      #1;
      if (blocks_done != base) break;
      chk("in_ready_held", 32'(in_ready), 32'd0);
      t++;
    end
    chk("first_block_done", 32'(blocks_done - base), 32'd1);
    @(negedge clock);
    #1;
    chk("in_ready_freed", 32'(in_ready), 32'd1);
    send_block(rand_block());
    wait_drain("drain_b2b");

    // random streams
    for (int n = 0; n < 10; n++) begin
      rdy_mode = ($urandom_range(0, 3) == 0) ? 1 : 2;
      send_block(rand_block());
    end
    wait_drain("drain_random");

    // reset while mid-AC with a second block buffered
    rdy_mode = 0;
    b = '0;
    for (int k = 0; k < 64; k++) b = set_coef(b, k, 8'($urandom_range(1, 255)));
    send_block(b);
    send_block(rand_block());
    rdy_mode = 1;
    repeat (8) @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    @(negedge clock);
    #1;
    reset_n = 1'b1;
    rdy_mode = 2;
    b = '0; b = set_coef(b, 0, 8'h3C); b = set_coef(b, 2, 8'h81);
    send_block(b);
    wait_drain("drain_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
